// File: rtl/adpcm_decode_sequencer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// adpcm_decode_sequencer
//   Byte-stream front end for an IMA ADPCM decoder. Each accepted byte is
//   split into two 4-bit codes. Each code is pushed through inverse_quantizer
//   together with the current step size and predictor, and the result is
//   presented on a valid/ready sample port. The block owns the decoder state:
//   predictor, step index and the 89-entry IMA step table.
//
// Ports
//   clk          clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   init_valid   block header present (init_sample / init_index)
//   init_ready   header can be accepted this cycle
//   init_sample  signed starting predictor
//   init_index   starting step index (clamped to INDEX_MAX on load)
//   in_valid     packed ADPCM byte present
//   in_ready     byte can be accepted this cycle
//   in_data      two packed 4-bit codes
//   out_valid    sample_out holds a decoded sample
//   out_ready    downstream accepts sample
//   sample_out   signed decoded PCM sample
//
// FSM states
//   state      | meaning
//   UNINIT     | no header seen since reset, only a header is accepted
//   IDLE       | waiting for a header or a byte (header wins)
//   DEC_FIRST  | decoding first nibble, result registered at end of cycle
//   OUT_FIRST  | first sample presented, waiting for out_ready
//   DEC_SECOND | decoding second nibble
//   OUT_SECOND | second sample presented, waiting for out_ready
// ----------------------------------------------------------------------------
module adpcm_decode_sequencer #(
    parameter int LOW_NIBBLE_FIRST = 1,
    parameter int INDEX_MAX        = 88
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init_valid,
    output logic               init_ready,
    input  logic signed [15:0] init_sample,
    input  logic [6:0]         init_index,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] sample_out
);

    typedef enum logic [2:0] {
        UNINIT     = 3'd0,
        IDLE       = 3'd1,
        DEC_FIRST  = 3'd2,
        OUT_FIRST  = 3'd3,
        DEC_SECOND = 3'd4,
        OUT_SECOND = 3'd5
    } state_t;

    state_t             state;
    state_t             state_next;
    logic signed [15:0] predictor;
    logic [6:0]         step_index;
    logic [7:0]         byte_reg;

    logic               use_low;
    logic [3:0]         code;
    logic [15:0]        step;
    logic signed [15:0] iq_sample;
    logic signed [7:0]  adj;
    logic signed [7:0]  idx_sum;
    logic [6:0]         index_next;
    logic [6:0]         init_index_clamped;
    logic               header_take;
    logic               byte_take;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= UNINIT;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            UNINIT:     if (init_valid) state_next = IDLE;
            IDLE:       if (!init_valid && in_valid) state_next = DEC_FIRST;
            DEC_FIRST:  state_next = OUT_FIRST;
            OUT_FIRST:  if (out_ready) state_next = DEC_SECOND;
            DEC_SECOND: state_next = OUT_SECOND;
            OUT_SECOND: if (out_ready) state_next = IDLE;
            default:    state_next = UNINIT;
        endcase
    end

    // ---------------- output / control decode ----------------
    always_comb begin
        init_ready = 1'b0;
        in_ready   = 1'b0;
        case (state)
            UNINIT: init_ready = 1'b1;
            IDLE: begin
                init_ready = 1'b1;
                in_ready   = 1'b1;
            end
            default: ;
        endcase
        // The nibble order flips between first and second decode; the
        // parameter picks which half of the byte goes first.
        use_low = (state == DEC_SECOND) ^ (LOW_NIBBLE_FIRST != 0);
    end

    assign header_take = init_valid & init_ready;
    // A header in the same cycle blocks the byte so only one thing loads.
    assign byte_take   = in_valid & in_ready & ~init_valid;
    assign code        = use_low ? byte_reg[3:0] : byte_reg[7:4];

    assign init_index_clamped = (init_index > 7'(INDEX_MAX)) ? 7'(INDEX_MAX) : init_index;

    // ---------------- index adaptation ----------------
    always_comb begin
        case (code[2:0])
            3'd4:    adj = 8'sd2;
            3'd5:    adj = 8'sd4;
            3'd6:    adj = 8'sd6;
            3'd7:    adj = 8'sd8;
            default: adj = -8'sd1;
        endcase
        idx_sum = $signed({1'b0, step_index}) + adj;
        if (idx_sum < 8'sd0) begin
            index_next = 7'd0;
        end else if (idx_sum > $signed(8'(INDEX_MAX))) begin
            index_next = 7'(INDEX_MAX);
        end else begin
            index_next = idx_sum[6:0];
        end
    end

    // ---------------- IMA step table ----------------
    always_comb begin
        case (step_index)
            7'd0:  step = 16'd7;     7'd1:  step = 16'd8;     7'd2:  step = 16'd9;
            7'd3:  step = 16'd10;    7'd4:  step = 16'd11;    7'd5:  step = 16'd12;
            7'd6:  step = 16'd13;    7'd7:  step = 16'd14;    7'd8:  step = 16'd16;
            7'd9:  step = 16'd17;    7'd10: step = 16'd19;    7'd11: step = 16'd21;
            7'd12: step = 16'd23;    7'd13: step = 16'd25;    7'd14: step = 16'd28;
            7'd15: step = 16'd31;    7'd16: step = 16'd34;    7'd17: step = 16'd37;
            7'd18: step = 16'd41;    7'd19: step = 16'd45;    7'd20: step = 16'd50;
            7'd21: step = 16'd55;    7'd22: step = 16'd60;    7'd23: step = 16'd66;
            7'd24: step = 16'd73;    7'd25: step = 16'd80;    7'd26: step = 16'd88;
            7'd27: step = 16'd97;    7'd28: step = 16'd107;   7'd29: step = 16'd118;
            7'd30: step = 16'd130;   7'd31: step = 16'd143;   7'd32: step = 16'd157;
            7'd33: step = 16'd173;   7'd34: step = 16'd190;   7'd35: step = 16'd209;
            7'd36: step = 16'd230;   7'd37: step = 16'd253;   7'd38: step = 16'd279;
            7'd39: step = 16'd307;   7'd40: step = 16'd337;   7'd41: step = 16'd371;
            7'd42: step = 16'd408;   7'd43: step = 16'd449;   7'd44: step = 16'd494;
            7'd45: step = 16'd544;   7'd46: step = 16'd598;   7'd47: step = 16'd658;
            7'd48: step = 16'd724;   7'd49: step = 16'd796;   7'd50: step = 16'd876;
            7'd51: step = 16'd963;   7'd52: step = 16'd1060;  7'd53: step = 16'd1166;
            7'd54: step = 16'd1282;  7'd55: step = 16'd1411;  7'd56: step = 16'd1552;
            7'd57: step = 16'd1707;  7'd58: step = 16'd1878;  7'd59: step = 16'd2066;
            7'd60: step = 16'd2272;  7'd61: step = 16'd2499;  7'd62: step = 16'd2749;
            7'd63: step = 16'd3024;  7'd64: step = 16'd3327;  7'd65: step = 16'd3660;
            7'd66: step = 16'd4026;  7'd67: step = 16'd4428;  7'd68: step = 16'd4871;
            7'd69: step = 16'd5358;  7'd70: step = 16'd5894;  7'd71: step = 16'd6484;
            7'd72: step = 16'd7132;  7'd73: step = 16'd7845;  7'd74: step = 16'd8630;
            7'd75: step = 16'd9493;  7'd76: step = 16'd10442; 7'd77: step = 16'd11487;
            7'd78: step = 16'd12635; 7'd79: step = 16'd13899; 7'd80: step = 16'd15289;
            7'd81: step = 16'd16818; 7'd82: step = 16'd18500; 7'd83: step = 16'd20350;
            7'd84: step = 16'd22385; 7'd85: step = 16'd24623; 7'd86: step = 16'd27086;
            7'd87: step = 16'd29794;
            default: step = 16'd32767;
        endcase
    end

    inverse_quantizer u_iq (
        .code   (code),
        .step   (step),
        .prev   (predictor),
        .sample (iq_sample)
    );

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            predictor  <= '0;
            step_index <= '0;
            byte_reg   <= '0;
            out_valid  <= 1'b0;
            sample_out <= '0;
        end else begin
            if (header_take) begin
                predictor  <= init_sample;
                step_index <= init_index_clamped;
            end
            if (byte_take) begin
                byte_reg <= in_data;
            end
            if (state == DEC_FIRST || state == DEC_SECOND) begin
                predictor  <= iq_sample;
                sample_out <= iq_sample;
                step_index <= index_next;
                out_valid  <= 1'b1;
            end
            if ((state == OUT_FIRST || state == OUT_SECOND) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// ----------------------------------------------------------------------------
// inverse_quantizer
//   IMA ADPCM reconstruction: diff = step/8 + step*code[2] + step/2*code[1]
//   + step/4*code[0], added to or subtracted from prev (code[3] = sign),
//   saturated to the signed 16-bit range.
//
// Ports
//   code    4-bit ADPCM code
//   step    current step size
//   prev    previous sample (predictor)
//   sample  reconstructed, saturated sample
// ----------------------------------------------------------------------------
module inverse_quantizer (
    input  logic [3:0]         code,
    input  logic [15:0]        step,
    input  logic signed [15:0] prev,
    output logic signed [15:0] sample
);

    logic [16:0]        diff;
    logic signed [17:0] sum;

    always_comb begin
        diff = 17'(step >> 3);
        if (code[2]) diff = diff + 17'(step);
        if (code[1]) diff = diff + 17'(step >> 1);
        if (code[0]) diff = diff + 17'(step >> 2);
        if (code[3]) begin
            sum = $signed({{2{prev[15]}}, prev}) - $signed({1'b0, diff});
        end else begin
            sum = $signed({{2{prev[15]}}, prev}) + $signed({1'b0, diff});
        end
        if (sum > 18'sd32767) begin
            sample = 16'sh7fff;
        end else if (sum < -18'sd32768) begin
            sample = 16'sh8000;
        end else begin
            sample = sum[15:0];
        end
    end

endmodule

// File: tb/tb_adpcm_decode_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for adpcm_decode_sequencer. Two instances run in
// lockstep: the default nibble order and the reversed order fed with the
// nibble-swapped byte, so both must produce the same sample stream.
module tb_adpcm_decode_sequencer;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               init_valid;
    logic signed [15:0] init_sample;
    logic [6:0]         init_index;
    logic               in_valid;
    logic [7:0]         in_data;
    logic [7:0]         in_data_hi;
    logic               out_ready;
    logic               init_ready, in_ready, out_valid;
    logic signed [15:0] sample_out;
    logic               init_ready_hi, in_ready_hi, out_valid_hi;
    logic signed [15:0] sample_out_hi;

    assign in_data_hi = {in_data[3:0], in_data[7:4]};

    adpcm_decode_sequencer #(.LOW_NIBBLE_FIRST(1), .INDEX_MAX(88)) dut (
        .clk(clk), .rst_n(rst_n),
        .init_valid(init_valid), .init_ready(init_ready),
        .init_sample(init_sample), .init_index(init_index),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .sample_out(sample_out)
    );

    adpcm_decode_sequencer #(.LOW_NIBBLE_FIRST(0), .INDEX_MAX(88)) dut_hi (
        .clk(clk), .rst_n(rst_n),
        .init_valid(init_valid), .init_ready(init_ready_hi),
        .init_sample(init_sample), .init_index(init_index),
        .in_valid(in_valid), .in_ready(in_ready_hi), .in_data(in_data_hi),
        .out_valid(out_valid_hi), .out_ready(out_ready), .sample_out(sample_out_hi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (bound expired or unexpected event)", name);
    endtask

    // ---------------- reference model ----------------
    int step_tbl [0:88] = '{
        7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41,
        45, 50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190,
        209, 230, 253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724,
        796, 876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066, 2272,
        2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132,
        7845, 8630, 9493, 10442, 11487, 12635, 13899, 15289, 16818, 18500,
        20350, 22385, 24623, 27086, 29794, 32767};
    int m_pred = 0;
    int m_idx = 0;
    int exp_q[$];

    function automatic int iq(input int code, input int stp, input int pred);
        int d;
        d = stp / 8;
        if ((code & 4) != 0) d += stp;
        if ((code & 2) != 0) d += stp / 2;
        if ((code & 1) != 0) d += stp / 4;
        if ((code & 8) != 0) pred -= d; else pred += d;
        if (pred > 32767) pred = 32767;
        if (pred < -32768) pred = -32768;
        return pred;
    endfunction

    task automatic model_nibble(input int code);
        int mag;
        m_pred = iq(code, step_tbl[m_idx], m_pred);
        exp_q.push_back(m_pred);
        mag = code & 7;
        m_idx += (mag < 4) ? -1 : 2 * (mag - 3);
        if (m_idx < 0) m_idx = 0;
        if (m_idx > 88) m_idx = 88;
    endtask

    // ---------------- scoreboard / stability monitor ----------------
    bit stall = 0;
    int held = 0;
    always @(negedge clk) begin
        int e;
        if (!rst_n) begin
            stall = 0;
        end else begin
            if (stall) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_sample", int'(sample_out), held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_sample");
                end else begin
                    e = exp_q.pop_front();
                    check("sample", int'(sample_out), e);
                    check("sample_hi", int'(sample_out_hi), e);
                    check("valid_hi", int'(out_valid_hi), 1);
                end
            end
            stall = out_valid && !out_ready;
            held = int'(sample_out);
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic load_header(input logic signed [15:0] s, input logic [6:0] i);
        bit acc = 0;
        int n = 0;
        init_sample = s;
        init_index = i;
        init_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = init_ready;
            @(posedge clk);
            #1;
            n++;
        end
        init_valid = 1'b0;
        if (!acc) fail_now("header_timeout");
        else begin
            m_pred = int'(s);
            m_idx = (int'(i) > 88) ? 88 : int'(i);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit use_model,
                             input int e0, input int e1, output int acc_cyc);
        bit acc = 0;
        int n = 0;
        acc_cyc = 0;
        in_data = b;
        in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready && !init_valid;
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) fail_now("byte_timeout");
        else if (use_model) begin
            model_nibble(int'(b[3:0]));
            model_nibble(int'(b[7:4]));
        end else begin
            exp_q.push_back(e0);
            exp_q.push_back(e1);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_now("drain_timeout");
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now("out_valid_timeout");
    endtask

    bit rand_bp = 0;
    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic signed [15:0] s;
        logic [6:0]         idx;
        logic [7:0]         b;
        int                 e0;
        int                 e1;
        int                 eidx;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int a1, a2;
        vecs[0] = '{16'sd0,      7'd0,  8'h07, 11,     13,     7};
        vecs[1] = '{16'sd0,      7'd88, 8'h77, 32767,  32767,  88};
        vecs[2] = '{16'sd0,      7'd0,  8'h00, 0,      0,      0};
        vecs[3] = '{-16'sd32760, 7'd88, 8'hFF, -32768, -32768, 88};
        vecs[4] = '{16'sd100,    7'd5,  8'h3A, 93,     101,    3};
        vecs[5] = '{16'sd1000,   7'd20, 8'hC4, 1056,   989,    24};

        init_valid = 0; init_sample = 0; init_index = 0;
        in_valid = 0; in_data = 0; out_ready = 1;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_sample_out", int'(sample_out), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_init_ready", int'(init_ready), 1);
        check("rst_index", int'(dut.step_index), 0);
        check("rst_predictor", int'(dut.predictor), 0);
        rst_n = 1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            load_header(vecs[i].s, vecs[i].idx);
            send_byte(vecs[i].b, 1'b0, vecs[i].e0, vecs[i].e1, a1);
            @(negedge clk);
            check("lat_dec_cycle", int'(out_valid), 0);
            @(negedge clk);
            check("lat_first_valid", int'(out_valid), 1);
            wait_drain(50);
            check("vec_index", int'(dut.step_index), vecs[i].eidx);
            check("vec_in_ready", int'(in_ready), 1);
        end

        // throughput: back-to-back bytes with out_ready held high
        load_header(16'sd0, 7'd0);
        send_byte(8'h07, 1'b1, 0, 0, a1);
        send_byte(8'h12, 1'b1, 0, 0, a2);
        check("byte_period", a2 - a1, 5);
        wait_drain(50);

        // backpressure in OUT_FIRST with a header knocking
        load_header(16'sd0, 7'd0);
        out_ready = 0;
        send_byte(8'h07, 1'b1, 0, 0, a1);
        wait_out_valid();
        @(posedge clk);
        #1;
        init_sample = 16'sd555;
        init_index = 7'd3;
        init_valid = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_init_ready", int'(init_ready), 0);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_index", int'(dut.step_index), 8);
            check("bp_predictor", int'(dut.predictor), 11);
        end
        @(posedge clk);
        #1;
        init_valid = 0;
        out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_gap", int'(out_valid), 0);
        @(negedge clk);
        check("bp_second_valid", int'(out_valid), 1);
        wait_drain(50);
        check("bp_final_index", int'(dut.step_index), 7);

        // header and byte in the same IDLE cycle: header wins, byte waits
        init_sample = 16'sd100;
        init_index = 7'd5;
        init_valid = 1;
        in_data = 8'h3A;
        in_valid = 1;
        @(posedge clk);
        #1;
        check("prio_in_ready", int'(in_ready), 1);
        check("prio_out_valid", int'(out_valid), 0);
        check("prio_predictor", int'(dut.predictor), 100);
        check("prio_index", int'(dut.step_index), 5);
        m_pred = 100;
        m_idx = 5;
        init_valid = 0;
        send_byte(8'h3A, 1'b1, 0, 0, a1);
        check("prio_byte_next_edge", a1 - cyc, 0);
        wait_drain(50);

        // reset during OUT_SECOND
        load_header(16'sd0, 7'd0);
        out_ready = 0;
        send_byte(8'h07, 1'b1, 0, 0, a1);
        wait_out_valid();
        @(posedge clk);
        #1;
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;
        wait_out_valid();
        @(posedge clk);
        #2;
        rst_n = 0;
        exp_q.delete();
        #1;
        check("rst_mid_out_valid", int'(out_valid), 0);
        check("rst_mid_in_ready", int'(in_ready), 0);
        check("rst_mid_init_ready", int'(init_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1;
        out_ready = 1;
        in_data = 8'h55;
        in_valid = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("uninit_in_ready", int'(in_ready), 0);
            check("uninit_out_valid", int'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        in_valid = 0;
        load_header(-16'sd5, 7'd120);
        @(negedge clk);
        check("post_hdr_in_ready", int'(in_ready), 1);
        check("init_index_clamp", int'(dut.step_index), 88);
        check("post_hdr_predictor", int'(dut.predictor), -5);

        // random bytes under random backpressure
        @(posedge clk);
        #1;
        load_header(16'($urandom), 7'($urandom_range(0, 88)));
        rand_bp = 1;
        for (int k = 0; k < 16; k++) begin
            send_byte(8'($urandom), 1'b1, 0, 0, a1);
        end
        wait_drain(400);
        rand_bp = 0;
        @(posedge clk);
        #2;
        out_ready = 1;
        wait_drain(50);
        check("rand_index", int'(dut.step_index), m_idx);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adpcm_decode_sequencer.md
Name: adpcm_decode_sequencer

Overview:
Byte-stream front end for the IMA ADPCM decoder datapath. It accepts packed ADPCM bytes and unpacks each byte into two 4-bit codes. For each code it supplies inverse_quantizer with the code, the current step size and the previous sample, then registers the reconstructed sample. It owns the decoder state (predictor, step index, 89-entry step table) and presents samples on a valid/ready output port.

Parameters:
LOW_NIBBLE_FIRST, 1, 1 = decode bits [3:0] before [7:4]; 0 = reverse order
INDEX_MAX, 88, highest legal step index (step table has INDEX_MAX+1 entries)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
init_valid  input  1  block header present
init_ready  output  1  header can be accepted this cycle
init_sample  input  16  signed starting predictor
init_index  input  7  starting step index
in_valid  input  1  ADPCM byte present
in_ready  output  1  byte can be accepted this cycle
in_data  input  8  two packed 4-bit codes
out_valid  output  1  sample_out holds a decoded sample
out_ready  input  1  downstream accepts sample
sample_out  output  16  signed decoded PCM sample

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - state=UNINIT, predictor=0, index=0, byte register=0
  - out_valid=0, sample_out=0, in_ready=0, init_ready=1
- States:
  - UNINIT: init_ready=1, in_ready=0. init_valid -> load predictor and index, go to IDLE.
  - IDLE: init_ready=1, in_ready=1.
    - init_valid has priority over in_valid: if both are 1, only the header is taken, the byte is not consumed, and the state stays IDLE.
    - in_valid alone -> latch in_data, go to DEC_FIRST.
  - DEC_FIRST: one cycle. Drive inverse_quantizer with the first nibble, step_table[index] and the predictor. Register its output into both predictor and sample_out, update index, set out_valid=1, go to OUT_FIRST.
  - OUT_FIRST: hold out_valid and sample_out stable. out_ready -> out_valid=0, go to DEC_SECOND.
  - DEC_SECOND and OUT_SECOND: same as above for the second nibble. The out_ready handshake in OUT_SECOND returns to IDLE.
  - init_ready=0 and in_ready=0 in every DEC_* and OUT_* state. A header arriving mid-byte waits until IDLE.
- Latency and throughput:
  - Byte accepted at edge N -> first sample valid after edge N+1.
  - Second sample valid one cycle after the first is accepted.
  - With out_ready held at 1, one byte completes every 5 cycles.
- Nibble order: with LOW_NIBBLE_FIRST=1, in_data[3:0] is decoded first.
- Index update: index_next = index + adj(code[2:0]).
  - adj = -1 for codes 0..3; +2, +4, +6, +8 for codes 4..7.
  - Computed as signed 8-bit, then clamped to [0, INDEX_MAX].
  - code[3] (sign) does not affect adj.
- Step table: standard IMA table, combinational ROM indexed by the registered index.
  - Entry 0 = 7, entry 1 = 8, entry 8 = 16, entry 7 = 14, entry 88 = 32767.
  - Index values above INDEX_MAX cannot occur: init_index is clamped to INDEX_MAX on load.
- Predictor: takes the inverse_quantizer output verbatim. Saturation is performed there, not here.
- init_sample/init_index load is a single-cycle handshake (init_valid & init_ready). Loading does not emit a sample.
- Reset mid-operation: the pending byte and any undelivered sample are discarded. out_valid drops immediately and the block returns to UNINIT.
- Flow-control stability:
  - out_valid never deasserts without a handshake.
  - sample_out never changes while out_valid=1 and out_ready=0.

Test Plan:
- Header 0 / index 0, byte 0x07, out_ready=1 -> samples 11 then 13; internal index 8 then 7; in_ready returns high 5 cycles after byte acceptance.
- Same stimulus with LOW_NIBBLE_FIRST=0, byte 0x70 -> samples 11, 13.
- Header 0 / index 88, byte 0x77 -> index stays 88 after both nibbles. Header 0 / index 0, byte 0x00 -> index stays 0; samples 0 then 0 (step 7 >> 3 = 0).
- Header -32760 / index 88, byte 0xFF -> both samples -32768 (negative saturation through inverse_quantizer).
- Backpressure: out_ready=0 for 10 cycles in OUT_FIRST -> out_valid and sample_out stay constant, in_ready=0, a concurrent init_valid is not accepted. On release, the second sample follows 2 cycles later.
- Header 100 / index 5 asserted in the same cycle as in_valid in IDLE -> header loaded, byte still pending. rst_n low during OUT_SECOND -> out_valid=0 at once, state UNINIT, in_ready=0 until a new header.
